// File: rtl/t5_dmem.sv
// t5_dmem: Wishbone-style data-memory responder for the core's data bus.
// Services one request at a time from an internal word-wide RAM. It inserts WAIT
// wait states, then returns a one-cycle ack, or a one-cycle err if the address is
// out of range.
//
// Ports:
//   sclk     system clock, rising edge
//   srst     synchronous reset, active-high
//   dwb_adr  word address [31:2]
//   dwb_dto  write data from the core
//   dwb_sel  byte-lane select, bit n covers bits [8n+7:8n]
//   dwb_wre  1 = write, 0 = read
//   dwb_stb  transfer request, held until ack/err
//   dwb_dti  registered read data to the core
//   dwb_ack  transfer complete, one-cycle pulse
//   dwb_err  transfer rejected (address out of range), one-cycle pulse
module t5_dmem #(
    parameter int unsigned AW   = 10,
    parameter int unsigned WAIT = 1
) (
    input  logic        sclk,
    input  logic        srst,
    input  logic [31:2] dwb_adr,
    input  logic [31:0] dwb_dto,
    input  logic [3:0]  dwb_sel,
    input  logic        dwb_wre,
    input  logic        dwb_stb,
    output logic [31:0] dwb_dti,
    output logic        dwb_ack,
    output logic        dwb_err
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:2] adr_q, adr_d;
    logic [31:0] dto_q, dto_d;
    logic [3:0]  sel_q, sel_d;
    logic        wre_q, wre_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dti_q, dti_d;

    logic [31:0] mem [0:(2**AW)-1];

    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          complete;
    logic          mem_we;
    logic [31:0]   rd_word;

    assign word_idx = adr_q[AW+1:2];
    // Any set bit above the RAM index makes the access out of range.
    assign in_range = (adr_q >> AW) == 30'd0;
    assign complete = (state_q == StBusy) && dwb_stb && (cnt_q == 3'd0);
    // srst has priority: a reset on the completing edge must not write.
    assign mem_we   = complete && in_range && wre_q && !srst;
    // Asynchronous array read; the result is registered into dwb_dti on the
    // RESP-entry edge, so the port still behaves as a synchronous read.
    assign rd_word  = mem[word_idx];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dto_d   = dto_q;
        sel_d   = sel_q;
        wre_d   = wre_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dti_d   = dti_q;
        unique case (state_q)
            StIdle: begin
                if (dwb_stb) begin
                    adr_d   = dwb_adr;
                    dto_d   = dwb_dto;
                    sel_d   = dwb_sel;
                    wre_d   = dwb_wre;
                    cnt_d   = 3'(WAIT);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!dwb_stb) begin
                    state_d = StIdle;
                end else if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d = StResp;
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else begin
                        ack_d = 1'b1;
                        if (!wre_q) begin
                            dti_d = rd_word;
                        end
                    end
                end
            end
            // Dead cycle: dwb_stb is ignored here so a held strobe is not serviced twice.
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            adr_q   <= 30'd0;
            dto_q   <= 32'd0;
            sel_q   <= 4'd0;
            wre_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dti_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dto_q   <= dto_d;
            sel_q   <= sel_d;
            wre_q   <= wre_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dti_q   <= dti_d;
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge sclk) begin
        if (mem_we) begin
            for (int n = 0; n < 4; n++) begin
                if (sel_q[n]) begin
                    mem[word_idx][8*n +: 8] <= dto_q[8*n +: 8];
                end
            end
        end
    end

    assign dwb_dti = dti_q;
    assign dwb_ack = ack_q;
    assign dwb_err = err_q;

endmodule

// File: tb/tb_t5_dmem.sv
// Bench for t5_dmem: three instances (WAIT = 0, 1, 3) share the request bus and
// each has its own strobe. A word-level model of each RAM predicts the results.
module tb_t5_dmem;

    logic        sclk = 1'b0;
    logic        srst;
    logic [31:2] adr;
    logic [31:0] dto;
    logic [3:0]  sel;
    logic        wre;
    logic [2:0]  stb;
    logic [31:0] dti0, dti1, dti2;
    logic [2:0]  ack, err;

    int ncmp = 0;
    int nerr = 0;

    int          waits [3] = '{0, 1, 3};
    logic [31:0] mdl [3][1024];
    bit          wr_ok [3][1024];
    logic [31:0] dti_exp [3];

    always #5 sclk = ~sclk;

    t5_dmem #(.AW(10), .WAIT(0)) u_w0 (
        .sclk(sclk), .srst(srst), .dwb_adr(adr), .dwb_dto(dto), .dwb_sel(sel),
        .dwb_wre(wre), .dwb_stb(stb[0]), .dwb_dti(dti0), .dwb_ack(ack[0]), .dwb_err(err[0])
    );
    t5_dmem #(.AW(10), .WAIT(1)) u_w1 (
        .sclk(sclk), .srst(srst), .dwb_adr(adr), .dwb_dto(dto), .dwb_sel(sel),
        .dwb_wre(wre), .dwb_stb(stb[1]), .dwb_dti(dti1), .dwb_ack(ack[1]), .dwb_err(err[1])
    );
    t5_dmem #(.AW(10), .WAIT(3)) u_w3 (
        .sclk(sclk), .srst(srst), .dwb_adr(adr), .dwb_dto(dto), .dwb_sel(sel),
        .dwb_wre(wre), .dwb_stb(stb[2]), .dwb_dti(dti2), .dwb_ack(ack[2]), .dwb_err(err[2])
    );

    function automatic logic [31:0] dti_of(input int d);
        if (d == 0) return dti0;
        if (d == 1) return dti1;
        return dti2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        @(negedge sclk);
    endtask

    // One complete transfer on instance d, starting and ending on a negedge.
    // The strobe is raised before capture edge k; ack/err must appear only in the
    // cycle after edge k+WAIT+1, and be gone after edge k+WAIT+2.
    task automatic txn(input int d, input logic [29:0] a, input logic [31:0] wd,
                       input logic [3:0] s, input logic w);
        logic [31:0] mask;
        bit          oor;
        int          lat;
        oor = (a >= 30'd1024);
        lat = waits[d] + 1;
        adr = a; dto = wd; sel = s; wre = w;
        stb[d] = 1'b1;
        if (!oor) begin
            if (w) begin
                mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
                mdl[d][a[9:0]]   = (mdl[d][a[9:0]] & ~mask) | (wd & mask);
                wr_ok[d][a[9:0]] = 1'b1;
            end else begin
                dti_exp[d] = mdl[d][a[9:0]];
            end
        end
        for (int j = 0; j <= lat; j++) begin
            tick();
            // Bus fields change after capture; the DUT must use its captured copy.
            if (j == 0) begin
                adr = 30'($urandom); dto = $urandom; sel = 4'($urandom); wre = 1'($urandom);
            end
            chk($sformatf("ack d%0d j%0d", d, j), 32'(ack[d]), 32'((j == lat) && !oor));
            chk($sformatf("err d%0d j%0d", d, j), 32'(err[d]), 32'((j == lat) && oor));
            if (j == lat) chk($sformatf("dti d%0d a%0h", d, a), dti_of(d), dti_exp[d]);
        end
        stb[d] = 1'b0;
        tick();
        chk($sformatf("ack_low d%0d", d), 32'(ack[d]), 32'd0);
        chk($sformatf("err_low d%0d", d), 32'(err[d]), 32'd0);
    endtask

    // Write request abandoned after one BUSY cycle, by dropping stb or by srst.
    task automatic abort_txn(input int d, input logic [29:0] a, input bit use_rst);
        adr = a; dto = $urandom; sel = 4'hF; wre = 1'b1;
        stb[d] = 1'b1;
        tick();
        tick();
        if (use_rst) begin
            srst = 1'b1;
            tick();
            srst = 1'b0;
            for (int i = 0; i < 3; i++) dti_exp[i] = 32'd0;
            chk("dti_after_rst", dti_of(d), 32'd0);
        end
        stb[d] = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk($sformatf("abort_ack j%0d", j), 32'(ack[d]), 32'd0);
            chk($sformatf("abort_err j%0d", j), 32'(err[d]), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [29:0] ra;
        logic        rw;
        int          acks;
        srst = 1'b1; stb = 3'b000; adr = 30'd0; dto = 32'd0; sel = 4'd0; wre = 1'b0;
        for (int i = 0; i < 3; i++) dti_exp[i] = 32'd0;

        // Reset then idle.
        tick();
        tick();
        srst = 1'b0;
        for (int j = 0; j < 10; j++) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("rst_ack d%0d", d), 32'(ack[d]), 32'd0);
                chk($sformatf("rst_err d%0d", d), 32'(err[d]), 32'd0);
                chk($sformatf("rst_dti d%0d", d), dti_of(d), 32'd0);
            end
            tick();
        end

        // WAIT=1 word write then read.
        txn(1, 30'h10, 32'hDEADBEEF, 4'hF, 1'b1);
        txn(1, 30'h10, $urandom, 4'($urandom), 1'b0);
        chk("rd_deadbeef", dti1, 32'hDEADBEEF);

        // Byte-lane merge and empty select.
        txn(1, 30'h5, 32'h11223344, 4'hF, 1'b1);
        txn(1, 30'h5, 32'hAABBCCDD, 4'h6, 1'b1);
        txn(1, 30'h5, 32'h0, 4'hF, 1'b0);
        chk("merge_sel6", dti1, 32'h11BBCC44);
        txn(1, 30'h5, $urandom, 4'h0, 1'b1);
        txn(1, 30'h5, 32'h0, 4'h3, 1'b0);
        chk("merge_sel0", dti1, 32'h11BBCC44);

        // Out of range: err pulse, dti keeps its previous value.
        txn(1, 30'h400, 32'h0, 4'hF, 1'b0);
        chk("oor_dti_kept", dti1, 32'h11BBCC44);

        // Abort by dropping stb, then by reset, at WAIT=3.
        txn(2, 30'h7, 32'hCAFEF00D, 4'hF, 1'b1);
        abort_txn(2, 30'h7, 1'b0);
        txn(2, 30'h7, 32'h0, 4'hF, 1'b0);
        chk("abort_unchanged", dti2, 32'hCAFEF00D);
        abort_txn(2, 30'h7, 1'b1);
        txn(2, 30'h7, 32'h0, 4'hF, 1'b0);
        chk("rst_abort_unchanged", dti2, 32'hCAFEF00D);

        // Held strobe at WAIT=0: acks at cycles 1, 4, 7 of 9.
        txn(0, 30'h3, 32'h5A5A1234, 4'hF, 1'b1);
        adr = 30'h3; wre = 1'b0; sel = 4'($urandom); dto = $urandom;
        stb[0] = 1'b1;
        acks = 0;
        for (int j = 0; j < 9; j++) begin
            tick();
            chk($sformatf("held_ack j%0d", j), 32'(ack[0]), 32'((j % 3) == 1));
            if (ack[0] === 1'b1) begin
                acks++;
                chk("held_dti", dti0, 32'h5A5A1234);
            end
        end
        stb[0] = 1'b0;
        tick();
        chk("held_ack_count", 32'(acks), 32'd3);
        dti_exp[0] = 32'h5A5A1234;

        // Randomized traffic against the model.
        for (int d = 0; d < 3; d++) begin
            for (int t = 0; t < 30; t++) begin
                if ($urandom_range(0, 9) == 0) begin
                    ra = 30'(1024 + $urandom_range(0, 5000));
                    rw = 1'($urandom);
                end else begin
                    ra = 30'($urandom_range(0, 15));
                    rw = wr_ok[d][ra[9:0]] ? 1'($urandom) : 1'b1;
                end
                txn(d, ra, $urandom, 4'($urandom), rw);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
